// File: rtl/date_counter.sv
// Calendar stage: day/month/year(2000-2099)/day-of-week driven by the daily
// rollover tick, with range-checked field loads that clamp day to month length.
module date_counter #(
  parameter logic [6:0] YEAR_RST = 7'd0,
  parameter logic [2:0] DOW_RST  = 3'd6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       day_tick,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic [6:0] set_val,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic [2:0] dow,
  output logic [4:0] mdays,
  output logic       month_wrap,
  output logic       year_wrap
);

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic [6:0] y);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
      4'd2:                    month_len = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 month_len = 5'd31;
    endcase
  endfunction

  logic [4:0] r_day;
  logic [3:0] r_month;
  logic [6:0] r_year;
  logic [2:0] r_dow;
  logic       r_month_wrap;
  logic       r_year_wrap;

  logic [4:0] w_mdays;
  logic [4:0] w_len_new_month;
  logic [4:0] w_len_new_year;
  logic       w_day_ok;
  logic       w_month_ok;
  logic       w_year_ok;
  logic       w_dow_ok;

  always_comb begin
    w_mdays         = month_len(r_month, r_year);
    // Candidate month lengths for the clamp that follows a month or year load
    w_len_new_month = month_len(set_val[3:0], r_year);
    w_len_new_year  = month_len(r_month, set_val);
    w_day_ok        = (set_val >= 7'd1) && (set_val <= {2'b00, w_mdays});
    w_month_ok      = (set_val >= 7'd1) && (set_val <= 7'd12);
    w_year_ok       = (set_val <= 7'd99);
    w_dow_ok        = (set_val <= 7'd6);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_day        <= 5'd1;
      r_month      <= 4'd1;
      r_year       <= YEAR_RST;
      r_dow        <= DOW_RST;
      r_month_wrap <= 1'b0;
      r_year_wrap  <= 1'b0;
    end else begin
      r_month_wrap <= 1'b0;
      r_year_wrap  <= 1'b0;
      // A load takes priority; a coincident tick is dropped
      if (set_en) begin
        case (set_sel)
          2'd0: if (w_day_ok) r_day <= set_val[4:0];
          2'd1: if (w_month_ok) begin
            r_month <= set_val[3:0];
            if (r_day > w_len_new_month) r_day <= w_len_new_month;
          end
          2'd2: if (w_year_ok) begin
            r_year <= set_val;
            if (r_day > w_len_new_year) r_day <= w_len_new_year;
          end
          default: if (w_dow_ok) r_dow <= set_val[2:0];
        endcase
      end else if (day_tick) begin
        r_dow <= (r_dow == 3'd6) ? 3'd0 : r_dow + 3'd1;
        if (r_day == w_mdays) begin
          r_day        <= 5'd1;
          r_month_wrap <= 1'b1;
          if (r_month == 4'd12) begin
            r_month     <= 4'd1;
            r_year      <= (r_year == 7'd99) ? 7'd0 : r_year + 7'd1;
            r_year_wrap <= 1'b1;
          end else begin
            r_month <= r_month + 4'd1;
          end
        end else begin
          r_day <= r_day + 5'd1;
        end
      end
    end
  end

  assign day        = r_day;
  assign month      = r_month;
  assign year       = r_year;
  assign dow        = r_dow;
  assign mdays      = w_mdays;
  assign month_wrap = r_month_wrap;
  assign year_wrap  = r_year_wrap;

endmodule

// File: tb/tb_date_counter.sv
// Directed bench for date_counter: reset, rollovers, leap years, set clamps,
// set/tick collision and a full leap year of back-to-back ticks.
module tb_date_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       day_tick = 1'b0;
  logic       set_en = 1'b0;
  logic [1:0] set_sel = 2'd0;
  logic [6:0] set_val = 7'd0;
  logic [4:0] day;
  logic [3:0] month;
  logic [6:0] year;
  logic [2:0] dow;
  logic [4:0] mdays;
  logic       month_wrap;
  logic       year_wrap;

  int n_checks = 0;
  int n_fail   = 0;

  date_counter #(.YEAR_RST(7'd0), .DOW_RST(3'd6)) dut (
    .clk(clk), .rst(rst), .day_tick(day_tick), .set_en(set_en),
    .set_sel(set_sel), .set_val(set_val), .day(day), .month(month),
    .year(year), .dow(dow), .mdays(mdays), .month_wrap(month_wrap),
    .year_wrap(year_wrap)
  );

  always #5 clk = ~clk;

  // {day, month, year, dow, month_wrap, year_wrap}
  function automatic logic [20:0] pack_state(input logic [4:0] d, input logic [3:0] m,
                                             input logic [6:0] y, input logic [2:0] w,
                                             input logic mw, input logic yw);
    pack_state = {d, m, y, w, mw, yw};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_set(input logic [1:0] sel, input logic [6:0] val);
    set_en = 1'b1; set_sel = sel; set_val = val;
    step();
    set_en = 1'b0;
  endtask

  task automatic set_date(input int y, input int m, input int d, input int w);
    do_set(2'd2, 7'(y));
    do_set(2'd1, 7'(m));
    do_set(2'd0, 7'(d));
    do_set(2'd3, 7'(w));
  endtask

  task automatic tick();
    day_tick = 1'b1;
    step();
    day_tick = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] got;
    #1 rst = 1'b1;
    #1;
    got = pack_state(day, month, year, dow, month_wrap, year_wrap);
    n_checks++;
    if (got !== pack_state(5'd1, 4'd1, 7'd0, 3'd6, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL reset_initial got=%h exp=%h", got, pack_state(5'd1, 4'd1, 7'd0, 3'd6, 1'b0, 1'b0));
    end
    @(negedge clk) rst = 1'b0;
    step();
    // Reach a month end so a wrap pulse is live when reset hits
    set_date(0, 1, 31, 2);
    tick();
    #2 rst = 1'b1;
    #1;
    got = pack_state(day, month, year, dow, month_wrap, year_wrap);
    n_checks++;
    if (got !== pack_state(5'd1, 4'd1, 7'd0, 3'd6, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL reset_midrun got=%h exp=%h", got, pack_state(5'd1, 4'd1, 7'd0, 3'd6, 1'b0, 1'b0));
    end
    n_checks++;
    if (mdays !== 5'd31) begin
      n_fail++; $display("FAIL reset_mdays got=%0d exp=31", mdays);
    end
    @(negedge clk) rst = 1'b0;
    step();
  endtask

  task automatic test_month_end();
    logic [20:0] got;
    set_date(0, 1, 31, 3);
    tick();
    got = pack_state(day, month, year, dow, month_wrap, year_wrap);
    n_checks++;
    if (got !== pack_state(5'd1, 4'd2, 7'd0, 3'd4, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL month_end got=%h exp=%h", got, pack_state(5'd1, 4'd2, 7'd0, 3'd4, 1'b1, 1'b0));
    end
    n_checks++;
    if (mdays !== 5'd29) begin
      n_fail++; $display("FAIL mdays_feb00 got=%0d exp=29", mdays);
    end
    step();
    n_checks++;
    if ({month_wrap, year_wrap} !== 2'b00) begin
      n_fail++; $display("FAIL month_wrap_one_cycle got=%b exp=00", {month_wrap, year_wrap});
    end
  endtask

  task automatic test_leap();
    set_date(24, 2, 28, 0);
    tick();
    n_checks++;
    if ({day, month} !== {5'd29, 4'd2} || month_wrap !== 1'b0) begin
      n_fail++; $display("FAIL leap24_feb29 got=%0d/%0d mw=%b exp=29/2 mw=0", day, month, month_wrap);
    end
    tick();
    n_checks++;
    if ({day, month} !== {5'd1, 4'd3} || month_wrap !== 1'b1) begin
      n_fail++; $display("FAIL leap24_mar1 got=%0d/%0d mw=%b exp=1/3 mw=1", day, month, month_wrap);
    end
    set_date(23, 2, 28, 0);
    tick();
    n_checks++;
    if ({day, month, year} !== {5'd1, 4'd3, 7'd23}) begin
      n_fail++; $display("FAIL nonleap23 got=%0d/%0d/%0d exp=1/3/23", day, month, year);
    end
    set_date(0, 2, 28, 0);
    tick();
    n_checks++;
    if ({day, month, year} !== {5'd29, 4'd2, 7'd0}) begin
      n_fail++; $display("FAIL leap00 got=%0d/%0d/%0d exp=29/2/0", day, month, year);
    end
  endtask

  task automatic test_year_end();
    logic [20:0] got;
    set_date(99, 12, 31, 5);
    tick();
    got = pack_state(day, month, year, dow, month_wrap, year_wrap);
    n_checks++;
    if (got !== pack_state(5'd1, 4'd1, 7'd0, 3'd6, 1'b1, 1'b1)) begin
      n_fail++; $display("FAIL year_end got=%h exp=%h", got, pack_state(5'd1, 4'd1, 7'd0, 3'd6, 1'b1, 1'b1));
    end
    step();
    n_checks++;
    if ({month_wrap, year_wrap} !== 2'b00) begin
      n_fail++; $display("FAIL year_wrap_one_cycle got=%b exp=00", {month_wrap, year_wrap});
    end
  endtask

  task automatic test_set_clamp();
    logic [20:0] got;
    set_date(23, 3, 31, 1);
    do_set(2'd1, 7'd2);
    n_checks++;
    if ({day, month, year} !== {5'd28, 4'd2, 7'd23} || month_wrap !== 1'b0) begin
      n_fail++; $display("FAIL clamp_month got=%0d/%0d/%0d mw=%b exp=28/2/23 mw=0", day, month, year, month_wrap);
    end
    set_date(24, 2, 29, 1);
    do_set(2'd2, 7'd23);
    n_checks++;
    if ({day, month, year} !== {5'd28, 4'd2, 7'd23} || year_wrap !== 1'b0) begin
      n_fail++; $display("FAIL clamp_year got=%0d/%0d/%0d yw=%b exp=28/2/23 yw=0", day, month, year, year_wrap);
    end
    // Now 28-Feb-23, dow 1: every one of these loads is out of range
    do_set(2'd0, 7'd32);
    do_set(2'd0, 7'd29);
    do_set(2'd0, 7'd0);
    do_set(2'd1, 7'd13);
    do_set(2'd1, 7'd0);
    do_set(2'd2, 7'd100);
    do_set(2'd3, 7'd7);
    got = pack_state(day, month, year, dow, month_wrap, year_wrap);
    n_checks++;
    if (got !== pack_state(5'd28, 4'd2, 7'd23, 3'd1, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL invalid_sets got=%h exp=%h", got, pack_state(5'd28, 4'd2, 7'd23, 3'd1, 1'b0, 1'b0));
    end
    do_set(2'd0, 7'd1);
    n_checks++;
    if (day !== 5'd1) begin
      n_fail++; $display("FAIL set_day_min got=%0d exp=1", day);
    end
  endtask

  task automatic test_collision();
    logic [20:0] got;
    set_date(23, 1, 31, 2);
    set_en = 1'b1; set_sel = 2'd0; set_val = 7'd15; day_tick = 1'b1;
    step();
    set_en = 1'b0; day_tick = 1'b0;
    got = pack_state(day, month, year, dow, month_wrap, year_wrap);
    n_checks++;
    if (got !== pack_state(5'd15, 4'd1, 7'd23, 3'd2, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL collision got=%h exp=%h", got, pack_state(5'd15, 4'd1, 7'd23, 3'd2, 1'b0, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] got;
    int mw_cnt = 0;
    int yw_cnt = 0;
    set_date(24, 1, 1, 1);
    day_tick = 1'b1;
    for (int i = 0; i < 366; i++) begin
      step();
      mw_cnt += int'(month_wrap);
      yw_cnt += int'(year_wrap);
    end
    day_tick = 1'b0;
    got = pack_state(day, month, year, dow, 1'b0, 1'b0);
    n_checks++;
    if (got !== pack_state(5'd1, 4'd1, 7'd25, 3'd3, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL b2b_date got=%h exp=%h", got, pack_state(5'd1, 4'd1, 7'd25, 3'd3, 1'b0, 1'b0));
    end
    n_checks++;
    if (mw_cnt !== 12 || yw_cnt !== 1) begin
      n_fail++; $display("FAIL b2b_wrap_counts got mw=%0d yw=%0d exp mw=12 yw=1", mw_cnt, yw_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_month_end();
    test_leap();
    test_year_end();
    test_set_clamp();
    test_collision();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
